// File: rtl/multdiv_ctrl_pkg.sv
// Shared encodings and defaults for the mult/div sequencer.
package multdiv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_BUSY  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } md_state_t;

  localparam int MD_TIMEOUT_CYCLES = 40;
  localparam int MD_EXC_REG        = 30;
  localparam int MD_MULT_EXC_CODE  = 4;
  localparam int MD_DIV_EXC_CODE   = 5;

  // ALU opcodes of the two multi-cycle operations
  localparam logic [4:0] ALUOP_MULT = 5'b00110;
  localparam logic [4:0] ALUOP_DIV  = 5'b00111;

endpackage

// File: rtl/multdiv_ctrl_timeout.sv
// Cycle counter with synchronous clear and a terminal-count flag at TERMINAL-1.
// Holds at terminal count so it never wraps while its owner waits.
module md_timeout_counter #(
  parameter int TERMINAL = 40
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int W = $clog2(TERMINAL + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !tc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == W'(TERMINAL - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequences the multi-cycle mult/div unit: stalls D/X, issues a start pulse with
// latched operands, then injects the result or an rstatus exception write into X.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MD_TIMEOUT_CYCLES,
  parameter int EXC_REG        = MD_EXC_REG,
  parameter int MULT_EXC_CODE  = MD_MULT_EXC_CODE,
  parameter int DIV_EXC_CODE   = MD_DIV_EXC_CODE
) (
  input  logic        rise,
  input  logic        reset,
  input  logic        mult_dx,
  input  logic        div_dx,
  input  logic [4:0]  rd_dx,
  input  logic [31:0] read1_dx,
  input  logic [31:0] read2_dx,
  input  logic        flush_dx,
  input  logic        md_result_rdy,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        stall_dx,
  output logic        md_x_valid,
  output logic [31:0] md_x_data,
  output logic [4:0]  md_x_rd,
  output logic        md_busy
);

  localparam logic [4:0]  EXC_RD     = 5'(EXC_REG);
  localparam logic [31:0] MULT_EXC32 = 32'(MULT_EXC_CODE);
  localparam logic [31:0] DIV_EXC32  = 32'(DIV_EXC_CODE);

  md_state_t   state_q, state_d;
  logic [31:0] op_a_q, op_b_q, res_q;
  logic [4:0]  rd_q, op_q;
  logic        exc_q;

  logic start, latch, capture, cap_exc, cnt_clr, cnt_en, tmo;

  assign start = (mult_dx | div_dx) & ~flush_dx;

  md_timeout_counter #(
    .TERMINAL(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (rise),
    .rst_n (reset),
    .clear (cnt_clr),
    .enable(cnt_en),
    .tc    (tmo)
  );

  always_ff @(posedge rise or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    stall_dx = 1'b0;
    latch    = 1'b0;
    capture  = 1'b0;
    cap_exc  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          stall_dx = 1'b1;
          latch    = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_clr = 1'b1;
        if (flush_dx) begin
          state_d = ST_DRAIN;
        end else begin
          stall_dx = 1'b1;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_en = 1'b1;
        // A flush coinciding with completion has nothing left to drain.
        if (flush_dx) begin
          state_d = (md_result_rdy || tmo) ? ST_IDLE : ST_DRAIN;
        end else begin
          stall_dx = 1'b1;
          if (md_result_rdy) begin
            capture = 1'b1;
            cap_exc = md_exception;
            state_d = ST_DONE;
          end else if (tmo) begin
            capture = 1'b1;
            cap_exc = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        cnt_en   = 1'b1;
        stall_dx = start;
        if (md_result_rdy || tmo) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge rise or negedge reset) begin
    if (!reset) begin
      op_a_q <= '0;
      op_b_q <= '0;
      rd_q   <= '0;
      op_q   <= '0;
      res_q  <= '0;
      exc_q  <= 1'b0;
    end else begin
      if (latch) begin
        op_a_q <= read1_dx;
        op_b_q <= read2_dx;
        rd_q   <= rd_dx;
        op_q   <= mult_dx ? ALUOP_MULT : ALUOP_DIV;
      end
      if (capture) begin
        res_q <= md_result;
        exc_q <= cap_exc;
      end
    end
  end

  assign ctrl_mult   = (state_q == ST_ISSUE) && (op_q == ALUOP_MULT);
  assign ctrl_div    = (state_q == ST_ISSUE) && (op_q == ALUOP_DIV);
  assign md_operandA = op_a_q;
  assign md_operandB = op_b_q;
  assign md_busy     = (state_q != ST_IDLE);
  assign md_x_valid  = (state_q == ST_DONE);

  always_comb begin
    md_x_data = '0;
    md_x_rd   = '0;
    if (md_x_valid) begin
      if (exc_q) begin
        md_x_data = (op_q == ALUOP_DIV) ? DIV_EXC32 : MULT_EXC32;
        md_x_rd   = EXC_RD;
      end else begin
        md_x_data = res_q;
        md_x_rd   = rd_q;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl; the bench plays the multdiv unit and scores X-stage writes.
module tb_multdiv_ctrl;

  logic        rise = 1'b0;
  logic        reset;
  logic        mult_dx, div_dx, flush_dx;
  logic [4:0]  rd_dx;
  logic [31:0] read1_dx, read2_dx;
  logic        md_result_rdy, md_exception;
  logic [31:0] md_result;
  logic        ctrl_mult, ctrl_div, stall_dx, md_x_valid, md_busy;
  logic [31:0] md_operandA, md_operandB, md_x_data;
  logic [4:0]  md_x_rd;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc, n_cm, n_cd, n_st, n_val, n_busy, val_cyc;

  always #5 rise = ~rise;

  multdiv_ctrl dut (
    .rise(rise), .reset(reset), .mult_dx(mult_dx), .div_dx(div_dx), .rd_dx(rd_dx),
    .read1_dx(read1_dx), .read2_dx(read2_dx), .flush_dx(flush_dx),
    .md_result_rdy(md_result_rdy), .md_exception(md_exception), .md_result(md_result),
    .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .md_operandA(md_operandA),
    .md_operandB(md_operandB), .stall_dx(stall_dx), .md_x_valid(md_x_valid),
    .md_x_data(md_x_data), .md_x_rd(md_x_rd), .md_busy(md_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cyc = 0; n_cm = 0; n_cd = 0; n_st = 0; n_val = 0; n_busy = 0; val_cyc = -1;
  endtask

  // Called at a falling edge: sample settled outputs, score any X write, advance one cycle.
  task automatic step();
    exp_t e;
    #1;
    assert (!(mult_dx && div_dx)) else begin
      bad++;
      $error("FAIL decode: mult_dx and div_dx both driven");
    end
    if (ctrl_mult) n_cm++;
    if (ctrl_div)  n_cd++;
    if (stall_dx)  n_st++;
    if (md_busy)   n_busy++;
    if (md_x_valid) begin
      n_val++;
      val_cyc = cyc;
      if (sb.size() == 0) begin
        chk("x_valid_unexpected", 32'(md_x_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("x_data", md_x_data, e.data);
        chk("x_rd", 32'(md_x_rd), 32'(e.rd));
      end
    end
    @(negedge rise);
    cyc++;
  endtask

  // Acts as the multdiv unit: responds lat cycles after the start pulse (lat<0: never).
  task automatic finish_op(input int lat, input logic exc, input logic [31:0] res,
                           input logic [31:0] a, input logic [31:0] b);
    int pulse_at = -1;
    while (n_val == 0 && cyc < 120) begin
      md_result_rdy = (pulse_at >= 0 && lat >= 0 && cyc == pulse_at + lat);
      md_exception  = md_result_rdy & exc;
      md_result     = md_result_rdy ? res : 32'hdead_beef;
      if (pulse_at >= 0) begin
        read1_dx = ~a;
        read2_dx = ~b;
      end
      #1;
      if (ctrl_mult || ctrl_div) pulse_at = cyc;
      step();
    end
    mult_dx = 1'b0; div_dx = 1'b0;
    md_result_rdy = 1'b0; md_exception = 1'b0;
    chk("op_completed", 32'(n_val), 32'd1);
  endtask

  task automatic do_op(input logic div, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int lat, input logic exc,
                       input logic [31:0] res);
    exp_t e;
    e.rd   = (exc || lat < 0) ? 5'd30 : rd;
    e.data = (exc || lat < 0) ? (div ? 32'd5 : 32'd4) : res;
    sb.push_back(e);
    clr();
    mult_dx = ~div; div_dx = div;
    read1_dx = a; read2_dx = b; rd_dx = rd;
    finish_op(lat, exc, res, a, b);
    chk("operand_a_held", md_operandA, a);
    chk("operand_b_held", md_operandB, b);
    chk("start_pulses", 32'(n_cm + n_cd), 32'd1);
    chk("start_kind_div", 32'(n_cd), 32'(div));
  endtask

  initial begin
    reset = 1'b0; mult_dx = 1'b0; div_dx = 1'b0; flush_dx = 1'b0;
    rd_dx = '0; read1_dx = '0; read2_dx = '0;
    md_result_rdy = 1'b0; md_exception = 1'b0; md_result = '0;
    clr();

    // reset state
    repeat (2) @(negedge rise);
    #1;
    chk("rst_stall", 32'(stall_dx), 32'd0);
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_valid", 32'(md_x_valid), 32'd0);
    chk("rst_ctrl", 32'({ctrl_mult, ctrl_div}), 32'd0);
    chk("rst_x_data", md_x_data, 32'd0);
    chk("rst_opA", md_operandA, 32'd0);
    @(negedge rise);
    reset = 1'b1;
    step();

    // mult 7*6 -> 42 to r3, unit answers 16 cycles after the pulse
    do_op(1'b0, 32'd7, 32'd6, 5'd3, 16, 1'b0, 32'd42);
    chk("mul_latency", 32'(val_cyc), 32'd18);
    chk("mul_stall_cycles", 32'(n_st), 32'd18);
    chk("mul_busy_cycles", 32'(n_busy), 32'd18);
    step();
    chk("mul_single_valid", 32'(n_val), 32'd1);
    chk("mul_stall_released", 32'(n_st), 32'd18);

    // divide by zero flagged by the unit
    do_op(1'b1, 32'd10, 32'd0, 5'd12, 8, 1'b1, 32'h0);
    chk("div0_latency", 32'(val_cyc), 32'd10);
    step();
    chk("div0_single_valid", 32'(n_val), 32'd1);

    // unit never answers: timeout after 40 BUSY cycles
    do_op(1'b0, 32'd9, 32'd9, 5'd4, -1, 1'b0, 32'h0);
    chk("tmo_latency", 32'(val_cyc), 32'd42);
    chk("tmo_stall_cycles", 32'(n_st), 32'd42);
    step();
    chk("tmo_stall_released", 32'(stall_dx), 32'd0);
    chk("tmo_idle", 32'(md_busy), 32'd0);

    // flush in the fourth BUSY cycle, then a div waits behind the drain
    clr();
    mult_dx = 1'b1; read1_dx = 32'd3; read2_dx = 32'd4; rd_dx = 5'd7;
    repeat (5) step();
    flush_dx = 1'b1;
    step();
    flush_dx = 1'b0; mult_dx = 1'b0;
    #1;
    chk("flush_stall_dropped", 32'(stall_dx), 32'd0);
    chk("flush_drain_busy", 32'(md_busy), 32'd1);
    div_dx = 1'b1; read1_dx = 32'd20; read2_dx = 32'd4; rd_dx = 5'd9;
    sb.push_back('{data: 32'd5, rd: 5'd9});
    #1;
    chk("drain_stalls_div", 32'(stall_dx), 32'd1);
    while (cyc < 12) step();
    #1;
    chk("drain_still_stalled", 32'(stall_dx), 32'd1);
    md_result_rdy = 1'b1; md_result = 32'h1234_5678;
    step();
    md_result_rdy = 1'b0;
    finish_op(6, 1'b0, 32'd5, 32'd20, 32'd4);
    chk("flush_div_latency", 32'(val_cyc), 32'd21);
    chk("flush_div_pulse", 32'(n_cd), 32'd1);
    chk("flush_mult_pulse", 32'(n_cm), 32'd1);
    chk("flush_div_opA", md_operandA, 32'd20);
    step();
    chk("flush_single_valid", 32'(n_val), 32'd1);

    // reset in BUSY, then a stale rdy
    clr();
    mult_dx = 1'b1; read1_dx = 32'd11; read2_dx = 32'd2; rd_dx = 5'd5;
    repeat (4) step();
    reset = 1'b0; mult_dx = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall_dx), 32'd0);
    chk("midrst_busy", 32'(md_busy), 32'd0);
    chk("midrst_opA", md_operandA, 32'd0);
    chk("midrst_ctrl", 32'({ctrl_mult, ctrl_div}), 32'd0);
    step();
    reset = 1'b1;
    md_result_rdy = 1'b1; md_exception = 1'b1; md_result = 32'hbad0_0bad;
    step();
    md_result_rdy = 1'b0; md_exception = 1'b0;
    #1;
    chk("stale_rdy_busy", 32'(md_busy), 32'd0);
    chk("stale_rdy_valid", 32'(n_val), 32'd0);
    step();
    do_op(1'b0, 32'd11, 32'd2, 5'd5, 3, 1'b0, 32'd22);
    chk("post_rst_latency", 32'(val_cyc), 32'd5);

    // back-to-back mult then div, no gap cycle
    do_op(1'b0, 32'd100, 32'd3, 5'd6, 5, 1'b0, 32'd300);
    chk("b2b_mul_latency", 32'(val_cyc), 32'd7);
    do_op(1'b1, 32'd100, 32'd7, 5'd8, 4, 1'b0, 32'd14);
    chk("b2b_div_latency", 32'(val_cyc), 32'd6);
    step();
    chk("b2b_single_valid", 32'(n_val), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
